// File: rtl/truth_table_sweeper_if.sv
// Bus between the truth-table sweeper and the Boolean block / controller it serves.
// The slave side is the sweeper; the master side drives start and returns f.
interface truth_table_sweeper_if;
  logic       start;
  logic       f;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic [7:0] tt;
  logic       pass;
  logic [3:0] mismatch_cnt;

  modport slave (
    input  start, f,
    output a, b, c, busy, done, tt, pass, mismatch_cnt
  );

  modport master (
    output start, f,
    input  a, b, c, busy, done, tt, pass, mismatch_cnt
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps {A,B,C} through 0..7, samples F after a settle window per vector and
// grades the captured truth table against a golden one.
//
// state  | meaning
// IDLE   | waiting for start; results from the last sweep held
// SETTLE | current vector driven, counting settle cycles
// SAMPLE | capture F into tt[idx], advance to the next vector
// DONE   | one-cycle completion pulse; pass/mismatch_cnt valid
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'hD5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_sweeper_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYCLES);

  state_t     state;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [7:0] tt_q;
  logic [3:0] mm_q;

  logic [7:0] tt_final;
  logic [3:0] mm_final;

  // Grading uses the table as it will look once the last sample lands.
  always_comb begin
    tt_final    = tt_q;
    tt_final[7] = bus.f;
    mm_final    = '0;
    for (int i = 0; i < 8; i++) begin
      mm_final = mm_final + {3'b000, tt_final[i] ^ EXPECTED[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      tt_q   <= '0;
      mm_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state  <= SETTLE;
            idx    <= '0;
            cnt    <= '0;
            tt_q   <= '0;
            pass_q <= 1'b0;
            mm_q   <= '0;
            busy_q <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt < SETTLE_LIM) begin
            cnt <= cnt + 4'd1;
          end else begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          tt_q[idx] <= bus.f;
          if (idx != 3'd7) begin
            idx   <= idx + 3'd1;
            cnt   <= '0;
            state <= SETTLE;
          end else begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (tt_final == EXPECTED);
            mm_q   <= mm_final;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a            = idx[2];
  assign bus.b            = idx[1];
  assign bus.c            = idx[0];
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.tt           = tt_q;
  assign bus.pass         = pass_q;
  assign bus.mismatch_cnt = mm_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: nominal, failing-DUT, held-start,
// mid-sweep reset and zero-settle sweeps against F = (A&B) | ~C.
module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   f_mode;   // 0: Boolean model, 1: stuck 0, 2: stuck 1
  bit   sel;      // 0: default instance, 1: zero-settle instance

  truth_table_sweeper_if if0 ();
  truth_table_sweeper_if if1 ();

  truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(8'hD5)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(0), .EXPECTED(8'hD5)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  assign if0.f = (f_mode == 1) ? 1'b0 :
                 (f_mode == 2) ? 1'b1 : ((if0.a & if0.b) | ~if0.c);
  assign if1.f = (if1.a & if1.b) | ~if1.c;

  logic [2:0] abc_s;
  logic       busy_s;
  logic       done_s;
  logic [7:0] tt_s;
  logic       pass_s;
  logic [3:0] mm_s;

  assign abc_s  = sel ? {if1.a, if1.b, if1.c} : {if0.a, if0.b, if0.c};
  assign busy_s = sel ? if1.busy : if0.busy;
  assign done_s = sel ? if1.done : if0.done;
  assign tt_s   = sel ? if1.tt   : if0.tt;
  assign pass_s = sel ? if1.pass : if0.pass;
  assign mm_s   = sel ? if1.mismatch_cnt : if0.mismatch_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel) if1.start = v;
    else     if0.start = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_abc"},  {29'd0, abc_s}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_s}, 32'd0);
    check({tag, "_done"}, {31'd0, done_s}, 32'd0);
    check({tag, "_tt"},   {24'd0, tt_s}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass_s}, 32'd0);
    check({tag, "_mm"},   {28'd0, mm_s}, 32'd0);
  endtask

  // One sweep from a one-cycle start; optionally pokes start while busy.
  task automatic run_sweep(input string tag, input bit sel_i, input int per, input bit poke,
                           input logic [7:0] exp_tt, input logic [3:0] exp_mm);
    sel = sel_i;
    @(negedge clk);
    drive_start(1'b1);
    @(posedge clk); #1;
    check({tag, "_accept_busy"}, {31'd0, busy_s}, 32'd1);
    check({tag, "_accept_abc"},  {29'd0, abc_s}, 32'd0);
    drive_start(1'b0);
    for (int j = 1; j <= 8 * per; j++) begin
      @(posedge clk); #1;
      if (j < 8 * per) begin
        check($sformatf("%s_abc_e%0d", tag, j),  {29'd0, abc_s}, j / per);
        check($sformatf("%s_busy_e%0d", tag, j), {31'd0, busy_s}, 32'd1);
        check($sformatf("%s_done_e%0d", tag, j), {31'd0, done_s}, 32'd0);
      end else begin
        check({tag, "_done"},      {31'd0, done_s}, 32'd1);
        check({tag, "_done_busy"}, {31'd0, busy_s}, 32'd0);
        check({tag, "_done_abc"},  {29'd0, abc_s}, 32'd7);
        check({tag, "_tt"},        {24'd0, tt_s}, {24'd0, exp_tt});
        check({tag, "_pass"},      {31'd0, pass_s}, {31'd0, (exp_tt == 8'hD5)});
        check({tag, "_mm"},        {28'd0, mm_s}, {28'd0, exp_mm});
      end
      drive_start(poke && (j < 8 * per) && (j % 5 == 2));
    end
    drive_start(1'b0);
    @(posedge clk); #1;
    check({tag, "_after_done"}, {31'd0, done_s}, 32'd0);
    check({tag, "_after_busy"}, {31'd0, busy_s}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold_tt"}, {24'd0, tt_s}, {24'd0, exp_tt});
    check({tag, "_hold_mm"}, {28'd0, mm_s}, {28'd0, exp_mm});
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    f_mode    = 0;
    sel       = 1'b0;
    if0.start = 1'b0;
    if1.start = 1'b0;
    rst_n     = 1'b1;

    // Reset and idle behaviour
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    f_mode = 1;
    repeat (2) @(posedge clk);
    f_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("idle");
    f_mode = 0;

    run_sweep("nominal", 1'b0, 4, 1'b0, 8'hD5, 4'd0);
    run_sweep("busy_poke", 1'b0, 4, 1'b1, 8'hD5, 4'd0);

    f_mode = 1;
    run_sweep("stuck0", 1'b0, 4, 1'b0, 8'h00, 4'd5);
    f_mode = 2;
    run_sweep("stuck1", 1'b0, 4, 1'b0, 8'hFF, 4'd3);
    f_mode = 0;

    // Start held high: DONE at edge 32, re-accept at edge 34, second DONE at 66
    sel = 1'b0;
    @(negedge clk);
    if0.start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 66; j++) begin
      @(posedge clk); #1;
      if (j == 32 || j == 66) check($sformatf("held_done_e%0d", j), {31'd0, done_s}, 32'd1);
      else if (j == 31 || j == 33 || j == 65) check($sformatf("held_nodone_e%0d", j), {31'd0, done_s}, 32'd0);
      if (j == 33) check("held_idle_busy", {31'd0, busy_s}, 32'd0);
      if (j == 34) check("held_reaccept_busy", {31'd0, busy_s}, 32'd1);
      if (j == 34) check("held_reaccept_tt", {24'd0, tt_s}, 32'd0);
      if (j == 66) check("held_tt", {24'd0, tt_s}, 32'hD5);
    end
    if0.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("held_stop_busy", {31'd0, busy_s}, 32'd0);

    // Mid-sweep reset while vector 3 is driven
    @(negedge clk);
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("midrst_abc_before", {29'd0, abc_s}, 32'd3);
    check("midrst_tt_before", {24'd0, tt_s}, 32'h05);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk) rst_n = 1'b1;
    run_sweep("post_rst", 1'b0, 4, 1'b0, 8'hD5, 4'd0);

    run_sweep("settle0", 1'b1, 2, 1'b0, 8'hD5, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
